usb_tx_pkt_ctrl: RTL and testbench
==================================

Name: usb_tx_pkt_ctrl

Overview:
Packet-sequencing FSM for the USB TX path.
- Sequences one packet: inter-packet gap, SYNC, PID, payload bytes from the TX FIFO, optional CRC16, then EOP.
- Sits directly upstream of the TX bit timer: drives enable_timer_bits54/enable_timer_bits52 and consumes its bits54 rollover pulse to end the gap.
- Feeds bytes to the TX shift register/encoder and reports completion or error to the protocol controller.

Parameters:
- MAX_BYTES, 64, maximum payload byte count accepted; larger requests are errored.
- SYNC_BYTE, 8'h80, byte transmitted in the SYNC state.

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset, synchronous, active-high (name kept per codebase convention)
- tx_start  input  1  one-cycle request to send a packet; sampled only in IDLE
- short_gap  input  1  sampled with tx_start; 1 selects 52-count gap, 0 selects 54-count gap
- tx_pid  input  4  PID nibble, sampled with tx_start
- tx_size  input  7  payload byte count, sampled with tx_start
- fifo_data  input  8  TX FIFO head byte
- fifo_empty  input  1  TX FIFO empty flag
- byte_done  input  1  shifter pulse: loaded byte fully sent
- eop_done  input  1  encoder pulse: EOP finished
- bits54  input  1  gap timer rollover
- enable_timer_bits54  output  1  gap timer enable, 54-count
- enable_timer_bits52  output  1  gap timer enable, 52-count
- fifo_pop  output  1  one-cycle FIFO read strobe
- load_byte  output  1  one-cycle strobe; tx_byte valid this cycle
- tx_byte  output  8  byte to shifter
- send_eop  output  1  level; request EOP
- tx_busy  output  1  high in every state except IDLE
- tx_done  output  1  one-cycle success pulse
- tx_error  output  1  one-cycle error pulse

Behaviour:
- Reset values: state=IDLE; all outputs 0; tx_byte=8'h00; internal byte counter=0.
- Reset asserted mid-packet returns to IDLE on the next edge. No pulse is generated; enables drop at that edge.
- States:
  - IDLE: on tx_start, latch pid/size/short_gap and go to GAP. If tx_size>MAX_BYTES, pulse tx_error the next cycle and stay in IDLE.
  - GAP: exactly one of enable_timer_bits52 (short_gap=1) or enable_timer_bits54 (short_gap=0) is held high.
    - First cycle bits54=1: go to SYNC. Both enables are 0 from the next cycle, which clears the timer.
  - SYNC: pulse load_byte with tx_byte=SYNC_BYTE on entry, then wait for byte_done. Go to PID.
  - PID: pulse load_byte with tx_byte={~pid,pid} on entry, then wait for byte_done.
    - If size=0 (and no CRC), go to EOP; otherwise go to DATA.
  - DATA: on entry and after each byte_done:
    - If fifo_empty=1, pulse tx_error and go to EOP (abort with EOP).
    - Otherwise pulse fifo_pop and load_byte in the same cycle, with tx_byte=fifo_data.
    - The counter increments on each load; after byte_done of byte number size, go to CRC (if enabled) or EOP.
  - EOP: hold send_eop=1 until eop_done. Then return to IDLE with a tx_done pulse, unless that packet already pulsed tx_error.
- load_byte is never asserted while a previous byte's byte_done is outstanding.
- byte_done or eop_done arriving in an unrelated state is ignored.
- tx_start outside IDLE is ignored.
- A simultaneous byte_done and fifo_empty in DATA follows the empty rule.
- Latency: tx_start to first enable_timer_* high is 1 cycle. bits54 to SYNC load_byte is 1 cycle.

Optional Feature:
- Macro TX_CRC16_EN.
- When defined:
  - A CRC16 register (poly 0x8005, init 16'hFFFF, LSB-first) updates on every DATA byte loaded.
  - After the last data byte, a CRC state sends ~crc[7:0] then ~crc[15:8] as two load_byte/byte_done exchanges, then goes to EOP.
  - Size=0 sends CRC 16'h0000 (bytes 8'h00, 8'h00).
- When undefined: no CRC state or register; DATA and PID go directly to EOP.

Test Plan:
1. Reset held high 3 cycles during DATA -> next cycle all outputs 0, tx_busy=0, no tx_done or tx_error pulse.
2. tx_start, short_gap=0, pid=4'h3, size=0; bits54 after 54 cycles -> enable_timer_bits54 high 54 cycles; load_byte bytes 8'h80, 8'hC3 (plus CRC 8'h00, 8'h00 if TX_CRC16_EN); send_eop held; tx_done 1 cycle after eop_done.
3. short_gap=1, size=2, FIFO holds 8'hA5, 8'h5A -> only enable_timer_bits52 asserted; fifo_pop exactly 2 pulses; tx_byte sequence 80, pid byte, A5, 5A, then EOP.
4. size=3 with only 1 FIFO byte -> after first data byte_done: tx_error pulse, no second fifo_pop, send_eop, and no tx_done.
5. tx_size=70 -> tx_error pulse, no timer enable, state stays IDLE.
6. TX_CRC16_EN with data 8'h00, 8'h01 -> CRC bytes equal the reference-model CRC16 of {00,01}, inverted, low byte first.

Source files
------------

// File: rtl/usb_tx_pkt_ctrl.sv
// usb_tx_pkt_ctrl: USB TX packet sequencer.
// Sends one packet as inter-packet gap, SYNC, PID, FIFO payload, optional
// CRC16, then EOP, handshaking with the gap timer, the byte shifter and the
// EOP encoder.
// Optional feature macro: TX_CRC16_EN appends a CRC16 over the payload.
// All outputs are registered. Each output register is loaded from the value
// the FSM computes for the state it is entering. A strobe for a state entry
// therefore shows up in the first cycle of that state.
module usb_tx_pkt_ctrl #(
  parameter int         MAX_BYTES = 64,
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic       short_gap,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_size,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  input  logic       byte_done,
  input  logic       eop_done,
  input  logic       bits54,
  output logic       enable_timer_bits54,
  output logic       enable_timer_bits52,
  output logic       fifo_pop,
  output logic       load_byte,
  output logic [7:0] tx_byte,
  output logic       send_eop,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_SYNC = 3'd2,
    ST_PID  = 3'd3,
    ST_DATA = 3'd4,
    ST_EOP  = 3'd5
`ifdef TX_CRC16_EN
    ,
    ST_CRC  = 3'd6
`endif
  } state_t;

  localparam logic [7:0] MAX_SIZE = 8'(MAX_BYTES);

`ifdef TX_CRC16_EN
  // USB CRC16 (poly 0x8005), processed LSB first in reflected form (0xA001).
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[15:1]};
      if (fb) begin
        c = c ^ 16'hA001;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction
`endif

  state_t     r_state, w_state;
  logic [3:0] r_pid, w_pid;
  logic [6:0] r_size, w_size;
  logic       r_short, w_short;
  logic [6:0] r_count, w_count;
  logic       r_err, w_err;
  logic       r_en54, w_en54;
  logic       r_en52, w_en52;
  logic       r_pop, w_pop;
  logic       r_load, w_load;
  logic [7:0] r_tx_byte, w_tx_byte;
  logic       r_send_eop, w_send_eop;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_error, w_error;
  logic       w_byte_ack;
  logic       w_fetch;
  logic       w_finish;
`ifdef TX_CRC16_EN
  logic [15:0] r_crc, w_crc;
  logic        r_crc_idx, w_crc_idx;
`endif

  // Next-state and next-output logic for the packet sequencer.
  always_comb begin
    w_state    = r_state;
    w_pid      = r_pid;
    w_size     = r_size;
    w_short    = r_short;
    w_count    = r_count;
    w_err      = r_err;
    w_load     = 1'b0;
    w_tx_byte  = r_tx_byte;
    w_pop      = 1'b0;
    w_done     = 1'b0;
    w_error    = 1'b0;
    w_fetch    = 1'b0;
    w_finish   = 1'b0;
`ifdef TX_CRC16_EN
    w_crc      = r_crc;
    w_crc_idx  = r_crc_idx;
`endif
    // A byte_done in the same cycle as our own load cannot belong to it.
    w_byte_ack = byte_done & ~r_load;

    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          if ({1'b0, tx_size} > MAX_SIZE) begin
            w_error = 1'b1;
          end else begin
            w_state = ST_GAP;
            w_pid   = tx_pid;
            w_size  = tx_size;
            w_short = short_gap;
            w_count = 7'd0;
            w_err   = 1'b0;
`ifdef TX_CRC16_EN
            w_crc   = 16'hFFFF;
`endif
          end
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (bits54) begin
          w_state   = ST_SYNC;
          w_load    = 1'b1;
          w_tx_byte = SYNC_BYTE;
        end else begin
          w_state = ST_GAP;
        end
      end
      ST_SYNC: begin
        if (w_byte_ack) begin
          w_state   = ST_PID;
          w_load    = 1'b1;
          w_tx_byte = {~r_pid, r_pid};
        end else begin
          w_state = ST_SYNC;
        end
      end
      ST_PID: begin
        if (w_byte_ack) begin
          if (r_size == 7'd0) begin
            w_finish = 1'b1;
          end else begin
            w_fetch = 1'b1;
          end
        end else begin
          w_state = ST_PID;
        end
      end
      ST_DATA: begin
        if (w_byte_ack) begin
          if (r_count == r_size) begin
            w_finish = 1'b1;
          end else begin
            w_fetch = 1'b1;
          end
        end else begin
          w_state = ST_DATA;
        end
      end
`ifdef TX_CRC16_EN
      ST_CRC: begin
        if (w_byte_ack) begin
          if (r_crc_idx == 1'b0) begin
            w_load    = 1'b1;
            w_tx_byte = ~r_crc[15:8];
            w_crc_idx = 1'b1;
          end else begin
            w_state = ST_EOP;
          end
        end else begin
          w_state = ST_CRC;
        end
      end
`endif
      ST_EOP: begin
        if (eop_done) begin
          w_state = ST_IDLE;
          w_done  = ~r_err;
        end else begin
          w_state = ST_EOP;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Shared handling: fetch the next payload byte, or close the payload.
    case ({w_fetch, w_finish})
      2'b10: begin
        if (fifo_empty) begin
          w_error = 1'b1;
          w_err   = 1'b1;
          w_state = ST_EOP;
        end else begin
          w_state   = ST_DATA;
          w_pop     = 1'b1;
          w_load    = 1'b1;
          w_tx_byte = fifo_data;
          w_count   = r_count + 7'd1;
`ifdef TX_CRC16_EN
          w_crc     = crc16_byte(r_crc, fifo_data);
`endif
        end
      end
      2'b01: begin
`ifdef TX_CRC16_EN
        w_state   = ST_CRC;
        w_load    = 1'b1;
        w_tx_byte = ~r_crc[7:0];
        w_crc_idx = 1'b0;
`else
        w_state   = ST_EOP;
`endif
      end
      default: begin
        w_state = w_state;
      end
    endcase

    // Level outputs follow the state being entered.
    w_en54     = (w_state == ST_GAP) & ~w_short;
    w_en52     = (w_state == ST_GAP) & w_short;
    w_send_eop = (w_state == ST_EOP);
    w_busy     = (w_state != ST_IDLE);
  end

  // State, packet context and registered outputs.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state    <= ST_IDLE;
      r_pid      <= 4'h0;
      r_size     <= 7'd0;
      r_short    <= 1'b0;
      r_count    <= 7'd0;
      r_err      <= 1'b0;
      r_en54     <= 1'b0;
      r_en52     <= 1'b0;
      r_pop      <= 1'b0;
      r_load     <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_send_eop <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef TX_CRC16_EN
      r_crc      <= 16'hFFFF;
      r_crc_idx  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_pid      <= w_pid;
      r_size     <= w_size;
      r_short    <= w_short;
      r_count    <= w_count;
      r_err      <= w_err;
      r_en54     <= w_en54;
      r_en52     <= w_en52;
      r_pop      <= w_pop;
      r_load     <= w_load;
      r_tx_byte  <= w_tx_byte;
      r_send_eop <= w_send_eop;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_error    <= w_error;
`ifdef TX_CRC16_EN
      r_crc      <= w_crc;
      r_crc_idx  <= w_crc_idx;
`endif
    end
  end

  assign enable_timer_bits54 = r_en54;
  assign enable_timer_bits52 = r_en52;
  assign fifo_pop            = r_pop;
  assign load_byte           = r_load;
  assign tx_byte             = r_tx_byte;
  assign send_eop            = r_send_eop;
  assign tx_busy             = r_busy;
  assign tx_done             = r_done;
  assign tx_error            = r_error;

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Testbench for usb_tx_pkt_ctrl: directed packets with a queue scoreboard of
// expected load_byte / tx_error / tx_done events, plus behavioural models of
// the gap timer, byte shifter, EOP encoder and TX FIFO.
module tb_usb_tx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       tx_start = 1'b0;
  logic       short_gap = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_size = 7'd0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       byte_done = 1'b0;
  logic       eop_done = 1'b0;
  logic       bits54 = 1'b0;
  logic       enable_timer_bits54, enable_timer_bits52, fifo_pop, load_byte;
  logic [7:0] tx_byte;
  logic       send_eop, tx_busy, tx_done, tx_error;

  usb_tx_pkt_ctrl dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .short_gap(short_gap),
    .tx_pid(tx_pid), .tx_size(tx_size), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .byte_done(byte_done), .eop_done(eop_done),
    .bits54(bits54), .enable_timer_bits54(enable_timer_bits54),
    .enable_timer_bits52(enable_timer_bits52), .fifo_pop(fifo_pop),
    .load_byte(load_byte), .tx_byte(tx_byte), .send_eop(send_eop),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  localparam int EV_LOAD = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo_q[$];
  int tests = 0, fails = 0, cyc = 0;
  int en54_n = 0, en52_n = 0, pop_n = 0, eop_n = 0, busy_n = 0;
  int tcnt = 0, sdly = 0, ecnt = 0;
  int start_cyc = 0, first_en_cyc = -1, b54_cyc = -1, first_load_cyc = -1;
  int eop_cyc = -1, done_cyc = -1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int k, input logic [7:0] d, input string name);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event (data 0x%0h), required no event", name, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data != d) begin
        fails++;
        $display("FAIL %s: actual kind %0d data 0x%0h, required kind %0d data 0x%0h",
                 name, k, d, e.kind, e.data);
      end
    end
  endtask

`ifdef TX_CRC16_EN
  // Reference CRC16: MSB-first register with poly 0x8005 fed data LSB first,
  // result bit-reversed (equivalent to the USB reflected CRC16).
  function automatic logic [15:0] crc_ref(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] c;
    logic [15:0] r;
    logic [7:0]  bs [2];
    logic        fb;
    c = 16'hFFFF;
    bs[0] = b0;
    bs[1] = b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ bs[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15 - i];
    return r;
  endfunction

  task automatic push_crc(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] c;
    c = crc_ref(b0, b1);
    push(EV_LOAD, ~c[7:0]);
    push(EV_LOAD, ~c[15:8]);
  endtask
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Environment models: gap timer, byte shifter, EOP encoder, FIFO.
  always @(negedge clk) begin
    if (n_rst) begin
      bits54 = 1'b0; byte_done = 1'b0; eop_done = 1'b0;
      tcnt = 0; sdly = 0; ecnt = 0;
      fifo_q.delete();
    end else begin
      bits54 = 1'b0;
      if (enable_timer_bits54 | enable_timer_bits52) begin
        tcnt++;
        if (tcnt == 1) first_en_cyc = cyc;
        if (enable_timer_bits54) en54_n++;
        if (enable_timer_bits52) en52_n++;
        if (tcnt == (enable_timer_bits52 ? 52 : 54)) begin
          bits54 = 1'b1;
          b54_cyc = cyc;
        end
      end else begin
        tcnt = 0;
      end
      byte_done = 1'b0;
      if (load_byte) sdly = 3;
      else if (sdly > 0) begin
        sdly--;
        if (sdly == 0) byte_done = 1'b1;
      end
      eop_done = 1'b0;
      if (send_eop) begin
        eop_n++;
        ecnt++;
        if (ecnt == 4) begin
          eop_done = 1'b1;
          eop_cyc = cyc;
        end
      end else begin
        ecnt = 0;
      end
      if (fifo_pop) begin
        pop_n++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      if (tx_busy) busy_n++;
    end
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  end

  // Monitor: every DUT event is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!n_rst) begin
      if (load_byte) begin
        if (first_load_cyc < 0) first_load_cyc = cyc;
        expect_ev(EV_LOAD, tx_byte, "load_byte");
      end
      if (tx_error) expect_ev(EV_ERR, 8'h00, "tx_error");
      if (tx_done) begin
        done_cyc = cyc;
        expect_ev(EV_DONE, 8'h00, "tx_done");
      end
    end
  end

  task automatic send(input logic sg, input logic [3:0] pid, input logic [6:0] sz);
    en54_n = 0; en52_n = 0; pop_n = 0; eop_n = 0; busy_n = 0;
    first_load_cyc = -1; first_en_cyc = -1; b54_cyc = -1;
    eop_cyc = -1; done_cyc = -1;
    @(negedge clk);
    tx_start = 1'b1; short_gap = sg; tx_pid = pid; tx_size = sz;
    start_cyc = cyc;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " timeout"}, (n < 3000) ? 0 : 1, 0);
    repeat (3) @(negedge clk);
    check({name, " queue drained"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, int'({enable_timer_bits54, enable_timer_bits52, fifo_pop, load_byte,
                      send_eop, tx_busy, tx_done, tx_error, tx_byte}), 0);
  endtask

  initial begin
    int n;
    // Power-on reset
    repeat (3) @(negedge clk);
    check_outputs_zero("reset outputs");
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("post-reset idle");

    // Size 0, long gap
    push(EV_LOAD, 8'h80);
    push(EV_LOAD, 8'hC3);
`ifdef TX_CRC16_EN
    push(EV_LOAD, 8'h00);
    push(EV_LOAD, 8'h00);
`endif
    push(EV_DONE, 8'h00);
    send(1'b0, 4'h3, 7'd0);
    wait_idle("size0");
    check("size0 en54 cycles", en54_n, 54);
    check("size0 en52 cycles", en52_n, 0);
    check("size0 fifo_pop count", pop_n, 0);
    check("size0 start->enable latency", first_en_cyc - start_cyc, 1);
    check("size0 bits54->sync load latency", first_load_cyc - b54_cyc, 1);
    check("size0 eop_done->tx_done latency", done_cyc - eop_cyc, 1);

    // Size 2, short gap
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h5A);
    repeat (2) @(negedge clk);
    push(EV_LOAD, 8'h80);
    push(EV_LOAD, 8'h4B);
    push(EV_LOAD, 8'hA5);
    push(EV_LOAD, 8'h5A);
`ifdef TX_CRC16_EN
    push_crc(8'hA5, 8'h5A);
`endif
    push(EV_DONE, 8'h00);
    send(1'b1, 4'hB, 7'd2);
    wait_idle("size2");
    check("size2 en52 cycles", en52_n, 52);
    check("size2 en54 cycles", en54_n, 0);
    check("size2 fifo_pop count", pop_n, 2);

    // FIFO underrun: size 3, one byte available
    fifo_q.push_back(8'h33);
    repeat (2) @(negedge clk);
    push(EV_LOAD, 8'h80);
    push(EV_LOAD, 8'hE1);
    push(EV_LOAD, 8'h33);
    push(EV_ERR, 8'h00);
    send(1'b0, 4'h1, 7'd3);
    wait_idle("underrun");
    check("underrun fifo_pop count", pop_n, 1);
    check("underrun send_eop seen", (eop_n > 0) ? 1 : 0, 1);

    // Oversize request
    push(EV_ERR, 8'h00);
    send(1'b0, 4'h3, 7'd70);
    repeat (5) @(negedge clk);
    check("oversize queue drained", exp_q.size(), 0);
    check("oversize timer enables", en54_n + en52_n, 0);
    check("oversize busy cycles", busy_n, 0);

`ifdef TX_CRC16_EN
    // CRC over {00,01}
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h01);
    repeat (2) @(negedge clk);
    push(EV_LOAD, 8'h80);
    push(EV_LOAD, 8'hA5);
    push(EV_LOAD, 8'h00);
    push(EV_LOAD, 8'h01);
    push_crc(8'h00, 8'h01);
    push(EV_DONE, 8'h00);
    send(1'b0, 4'h5, 7'd2);
    wait_idle("crc");
    check("crc fifo_pop count", pop_n, 2);
`endif

    // Reset asserted during DATA
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    repeat (2) @(negedge clk);
    push(EV_LOAD, 8'h80);
    push(EV_LOAD, 8'hD2);
    push(EV_LOAD, 8'h11);
    send(1'b0, 4'h2, 7'd2);
    n = 0;
    while (pop_n == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midreset reached DATA", (n < 500) ? 1 : 0, 1);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset first edge");
    repeat (2) @(negedge clk);
    check_outputs_zero("midreset held");
    exp_q.delete();
    n_rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midreset busy after release", int'(tx_busy), 0);

    // Recovery packet after reset
    fifo_q.push_back(8'h7E);
    fifo_q.push_back(8'h81);
    repeat (2) @(negedge clk);
    push(EV_LOAD, 8'h80);
    push(EV_LOAD, 8'h69);
    push(EV_LOAD, 8'h7E);
    push(EV_LOAD, 8'h81);
`ifdef TX_CRC16_EN
    push_crc(8'h7E, 8'h81);
`endif
    push(EV_DONE, 8'h00);
    send(1'b0, 4'h9, 7'd2);
    wait_idle("recovery");
    check("recovery fifo_pop count", pop_n, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
